// File: rtl/accu_burst_feeder.sv
// Serializes a packed N_BEATS-sample word LSB-first onto a beat stream and reports each burst sum.
// Define ACCU_BURST_FEEDER_GAP_EN to insert one idle cycle between back-to-back bursts.
module accu_burst_feeder #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned N_BEATS = 4,
   parameter int unsigned SUM_W   = DATA_W + $clog2(N_BEATS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_W*N_BEATS-1:0] in_data,
   input  logic                      out_ready,
   output logic                      valid_out,
   output logic [DATA_W-1:0]         data_out,
   output logic                      last_out,
   output logic                      sum_valid,
   output logic [SUM_W-1:0]          sum_out
);

   localparam int unsigned      BeatW    = $clog2(N_BEATS);
   localparam logic [BeatW-1:0] LastBeat = BeatW'(N_BEATS - 1);

   typedef enum logic [0:0] {StIdle, StSend} state_e;

   state_e             state_q, state_d;
   logic [BeatW-1:0]   beat_q, beat_d, beat_inc;
   logic [DATA_W-1:0]  hold_q [N_BEATS];
   logic [DATA_W-1:0]  hold_d [N_BEATS];
   logic [SUM_W-1:0]   run_q, run_d;
   logic               valid_q, valid_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic               last_q, last_d;
   logic               sum_valid_q, sum_valid_d;
   logic [SUM_W-1:0]   sum_q, sum_d;
   logic               fire, fin, accept;

   always_comb begin
`ifdef ACCU_BURST_FEEDER_GAP_EN
      in_ready = (state_q == StIdle);
`else
      in_ready = (state_q == StIdle) ||
                 ((state_q == StSend) && (beat_q == LastBeat) && out_ready);
`endif
   end

   assign fire     = (state_q == StSend) && out_ready;
   assign fin      = fire && (beat_q == LastBeat);
   assign accept   = in_valid && in_ready;
   assign beat_inc = beat_q + BeatW'(1);

   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      hold_d      = hold_q;
      run_d       = run_q;
      valid_d     = valid_q;
      data_d      = data_q;
      last_d      = last_q;
      sum_valid_d = 1'b0;
      sum_d       = sum_q;

      // data_q always mirrors the beat currently on the bus, so it is the addend.
      if (fire) begin
         if (fin) begin
            sum_d       = run_q + SUM_W'(data_q);
            sum_valid_d = 1'b1;
            run_d       = '0;
         end else begin
            run_d = run_q + SUM_W'(data_q);
         end
      end

      if (accept) begin
         for (int k = 0; k < N_BEATS; k++) begin
            hold_d[k] = in_data[k*DATA_W +: DATA_W];
         end
         state_d = StSend;
         beat_d  = '0;
         valid_d = 1'b1;
         data_d  = in_data[DATA_W-1:0];
         last_d  = 1'b0;
      end else if (fin) begin
         state_d = StIdle;
         valid_d = 1'b0;
         last_d  = 1'b0;
      end else if (fire) begin
         beat_d = beat_inc;
         data_d = hold_q[beat_inc];
         last_d = (beat_inc == LastBeat);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         beat_q      <= '0;
         for (int k = 0; k < N_BEATS; k++) begin
            hold_q[k] <= '0;
         end
         run_q       <= '0;
         valid_q     <= 1'b0;
         data_q      <= '0;
         last_q      <= 1'b0;
         sum_valid_q <= 1'b0;
         sum_q       <= '0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         hold_q      <= hold_d;
         run_q       <= run_d;
         valid_q     <= valid_d;
         data_q      <= data_d;
         last_q      <= last_d;
         sum_valid_q <= sum_valid_d;
         sum_q       <= sum_d;
      end
   end

   assign valid_out = valid_q;
   assign data_out  = data_q;
   assign last_out  = last_q;
   assign sum_valid = sum_valid_q;
   assign sum_out   = sum_q;

endmodule

// File: tb/tb_accu_burst_feeder.sv
// Directed bench for accu_burst_feeder: a vector table for a single burst plus
// hand-written sequences for back-to-back, backpressure, max values and reset mid-burst.
module tb_accu_burst_feeder;

`ifdef ACCU_BURST_FEEDER_GAP_EN
   localparam bit Gap = 1'b1;
`else
   localparam bit Gap = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_ready;
   logic        valid_out;
   logic [7:0]  data_out;
   logic        last_out;
   logic        sum_valid;
   logic [9:0]  sum_out;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic        iv;
      logic [31:0] id;
      logic        ordy;
      logic        ev;
      logic [7:0]  ed;
      logic        el;
      logic        eir;
      logic        esv;
      logic [9:0]  es;
   } vec_t;

   vec_t tbl [7];

   accu_burst_feeder dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_ready (out_ready),
      .valid_out (valid_out),
      .data_out  (data_out),
      .last_out  (last_out),
      .sum_valid (sum_valid),
      .sum_out   (sum_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic ev, input logic [7:0] ed, input logic el,
                      input logic eir, input logic esv, input logic [9:0] es);
      n_vec++;
      if (valid_out !== ev) begin
         n_err++;
         $display("FAIL %s valid_out got %b want %b", nm, valid_out, ev);
      end
      if (ev && (data_out !== ed)) begin
         n_err++;
         $display("FAIL %s data_out got %h want %h", nm, data_out, ed);
      end
      if (last_out !== el) begin
         n_err++;
         $display("FAIL %s last_out got %b want %b", nm, last_out, el);
      end
      if (in_ready !== eir) begin
         n_err++;
         $display("FAIL %s in_ready got %b want %b", nm, in_ready, eir);
      end
      if (sum_valid !== esv) begin
         n_err++;
         $display("FAIL %s sum_valid got %b want %b", nm, sum_valid, esv);
      end
      if (sum_out !== es) begin
         n_err++;
         $display("FAIL %s sum_out got %h want %h", nm, sum_out, es);
      end
   endtask

   // Drive inputs just after a rising edge, check at the falling edge, advance one cycle.
   task automatic cyc(input string nm, input logic iv, input logic [31:0] id, input logic ordy,
                      input logic ev, input logic [7:0] ed, input logic el, input logic eir,
                      input logic esv, input logic [9:0] es);
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      @(negedge clk);
      chk(nm, ev, ed, el, eir, esv, es);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;

      tbl[0] = '{1'b1, 32'h04030201, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 10'h000};
      tbl[1] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 10'h000};
      tbl[2] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 10'h000};
      tbl[3] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 10'h000};
      tbl[4] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h04, 1'b1, !Gap, 1'b0, 10'h000};
      tbl[5] = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 10'h00A};
      tbl[6] = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 10'h00A};

      #12;
      chk("reset", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 10'h000);
      n_vec++;
      if (data_out !== 8'h00) begin
         n_err++;
         $display("FAIL reset_data data_out got %h want 00", data_out);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Single burst
      for (int i = 0; i < 7; i++) begin
         cyc($sformatf("tbl%0d", i), tbl[i].iv, tbl[i].id, tbl[i].ordy, tbl[i].ev, tbl[i].ed,
             tbl[i].el, tbl[i].eir, tbl[i].esv, tbl[i].es);
      end

      // Back-to-back: in_valid held, second word presented while the first is streaming
`ifdef ACCU_BURST_FEEDER_GAP_EN
      cyc("b2b_accA", 1, 32'h04030201, 1, 0, 8'h00, 0, 1, 0, 10'h00A);
      cyc("b2b_01",   1, 32'h08070605, 1, 1, 8'h01, 0, 0, 0, 10'h00A);
      cyc("b2b_02",   1, 32'h08070605, 1, 1, 8'h02, 0, 0, 0, 10'h00A);
      cyc("b2b_03",   1, 32'h08070605, 1, 1, 8'h03, 0, 0, 0, 10'h00A);
      cyc("b2b_04",   1, 32'h08070605, 1, 1, 8'h04, 1, 0, 0, 10'h00A);
      cyc("b2b_gap",  1, 32'h08070605, 1, 0, 8'h00, 0, 1, 1, 10'h00A);
      cyc("b2b_05",   0, 32'h0,        1, 1, 8'h05, 0, 0, 0, 10'h00A);
`else
      cyc("b2b_accA", 1, 32'h04030201, 1, 0, 8'h00, 0, 1, 0, 10'h00A);
      cyc("b2b_01",   1, 32'h08070605, 1, 1, 8'h01, 0, 0, 0, 10'h00A);
      cyc("b2b_02",   1, 32'h08070605, 1, 1, 8'h02, 0, 0, 0, 10'h00A);
      cyc("b2b_03",   1, 32'h08070605, 1, 1, 8'h03, 0, 0, 0, 10'h00A);
      cyc("b2b_04",   1, 32'h08070605, 1, 1, 8'h04, 1, 1, 0, 10'h00A);
      cyc("b2b_05",   0, 32'h0,        1, 1, 8'h05, 0, 0, 1, 10'h00A);
`endif
      cyc("b2b_06",  0, 32'h0, 1, 1, 8'h06, 0, 0, 0, 10'h00A);
      cyc("b2b_07",  0, 32'h0, 1, 1, 8'h07, 0, 0, 0, 10'h00A);
      cyc("b2b_08",  0, 32'h0, 1, 1, 8'h08, 1, !Gap, 0, 10'h00A);
      cyc("b2b_sum", 0, 32'h0, 1, 0, 8'h00, 0, 1, 1, 10'h01A);

      // Backpressure at beat1 for three cycles
      cyc("bp_acc",  1, 32'h40302010, 1, 0, 8'h00, 0, 1, 0, 10'h01A);
      cyc("bp_10",   0, 32'h0, 1, 1, 8'h10, 0, 0, 0, 10'h01A);
      cyc("bp_20s0", 0, 32'h0, 0, 1, 8'h20, 0, 0, 0, 10'h01A);
      cyc("bp_20s1", 0, 32'h0, 0, 1, 8'h20, 0, 0, 0, 10'h01A);
      cyc("bp_20s2", 0, 32'h0, 0, 1, 8'h20, 0, 0, 0, 10'h01A);
      cyc("bp_20",   0, 32'h0, 1, 1, 8'h20, 0, 0, 0, 10'h01A);
      cyc("bp_30",   0, 32'h0, 1, 1, 8'h30, 0, 0, 0, 10'h01A);
      cyc("bp_40",   0, 32'h0, 1, 1, 8'h40, 1, !Gap, 0, 10'h01A);
      cyc("bp_sum",  0, 32'h0, 1, 0, 8'h00, 0, 1, 1, 10'h0A0);

      // Max values: no truncation of the sum
      cyc("mx_acc", 1, 32'hFFFFFFFF, 1, 0, 8'h00, 0, 1, 0, 10'h0A0);
      cyc("mx_b0",  0, 32'h0, 1, 1, 8'hFF, 0, 0, 0, 10'h0A0);
      cyc("mx_b1",  0, 32'h0, 1, 1, 8'hFF, 0, 0, 0, 10'h0A0);
      cyc("mx_b2",  0, 32'h0, 1, 1, 8'hFF, 0, 0, 0, 10'h0A0);
      cyc("mx_b3",  0, 32'h0, 1, 1, 8'hFF, 1, !Gap, 0, 10'h0A0);
      cyc("mx_sum", 0, 32'h0, 1, 0, 8'h00, 0, 1, 1, 10'h3FC);

      // Reset mid-burst, asserted away from a clock edge
      cyc("rm_acc", 1, 32'h04030201, 1, 0, 8'h00, 0, 1, 0, 10'h3FC);
      cyc("rm_b0",  0, 32'h0, 1, 1, 8'h01, 0, 0, 0, 10'h3FC);
      @(negedge clk);
      chk("rm_b1", 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 10'h3FC);
      rst = 1'b1;
      #1;
      chk("rm_async", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 10'h000);
      n_vec++;
      if (data_out !== 8'h00) begin
         n_err++;
         $display("FAIL rm_async_data data_out got %h want 00", data_out);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      cyc("rm_idle0", 0, 32'h0, 1, 0, 8'h00, 0, 1, 0, 10'h000);
      cyc("rm_idle1", 0, 32'h0, 1, 0, 8'h00, 0, 1, 0, 10'h000);
      cyc("rm_acc2",  1, 32'h01010101, 1, 0, 8'h00, 0, 1, 0, 10'h000);
      cyc("rm_n0",    0, 32'h0, 1, 1, 8'h01, 0, 0, 0, 10'h000);
      cyc("rm_n1",    0, 32'h0, 1, 1, 8'h01, 0, 0, 0, 10'h000);
      cyc("rm_n2",    0, 32'h0, 1, 1, 8'h01, 0, 0, 0, 10'h000);
      cyc("rm_n3",    0, 32'h0, 1, 1, 8'h01, 1, !Gap, 0, 10'h000);
      cyc("rm_sum",   0, 32'h0, 1, 0, 8'h00, 0, 1, 1, 10'h004);
      cyc("rm_hold",  0, 32'h0, 1, 0, 8'h00, 0, 1, 0, 10'h004);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
